// File: rtl/sub_x1_pkg.sv
// Shared constants for the 1-bit full subtractor cell and its users.
// The truth table is indexed by {A, B, borrow_in} and yields {borrow_out, diff}.
package sub_x1_pkg;

  localparam int SUB_TABLE_DEPTH = 8;

  localparam logic [1:0] SUB_TRUTH_TABLE [SUB_TABLE_DEPTH] = '{
    2'b00, 2'b11, 2'b11, 2'b10,
    2'b01, 2'b00, 2'b00, 2'b11
  };

  // Table lookup helper for callers that prefer a ROM-style view of the cell.
  function automatic logic [1:0] subLookup(input logic [2:0] abc);
    return SUB_TRUTH_TABLE[abc];
  endfunction

endpackage

// File: rtl/sub_x1_core.sv
// Purely combinational full-subtractor equations (A - B - borrow_in).
// Kept separate so an N-bit ripple-borrow subtractor can chain it directly.
module sub_x1_core
  import sub_x1_pkg::*;
(
  input  logic A,
  input  logic B,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  logic abXor;

  assign abXor      = A ^ B;
  assign diff       = abXor ^ borrow_in;
  // A borrow leaves this stage when B exceeds A, or when A equals B and a
  // borrow arrives from below.
  assign borrow_out = (~A & B) | (~abXor & borrow_in);

endmodule

// File: rtl/sub_x1.sv
// 1-bit full subtractor with zero-latency result ports and an optional
// registered copy (result plus valid flag) for pipelined datapaths.
module sub_x1
  import sub_x1_pkg::*;
#(
  parameter bit REGISTERED = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic borrow_in,
  input  logic in_valid,
  output logic borrow_out,
  output logic diff,
  output logic borrow_out_q,
  output logic diff_q,
  output logic out_valid
);

  sub_x1_core u_core (
    .A          (A),
    .B          (B),
    .borrow_in  (borrow_in),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  generate
    if (REGISTERED) begin : gen_reg
      logic diffHold_q, diffHold_d;
      logic borrowHold_q, borrowHold_d;
      logic valid_q;

      // Capture a new result only when the inputs are qualified, otherwise hold.
      always_comb begin
        diffHold_d   = diffHold_q;
        borrowHold_d = borrowHold_q;
        if (in_valid) begin
          diffHold_d   = diff;
          borrowHold_d = borrow_out;
        end
      end

      // Output register; reset clears any captured result immediately.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          diffHold_q   <= 1'b0;
          borrowHold_q <= 1'b0;
          valid_q      <= 1'b0;
        end else begin
          diffHold_q   <= diffHold_d;
          borrowHold_q <= borrowHold_d;
          valid_q      <= in_valid;
        end
      end

      assign diff_q       = diffHold_q;
      assign borrow_out_q = borrowHold_q;
      assign out_valid    = valid_q;
    end else begin : gen_comb
      // Clock and reset play no part when the register stage is bypassed.
      logic unusedClkRst;
      assign unusedClkRst = clk ^ rst_n;

      assign diff_q       = diff;
      assign borrow_out_q = borrow_out;
      assign out_valid    = in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_sub_x1.sv
// Scoreboard bench for sub_x1: registered and pass-through variants share
// stimulus, plus a 4-bit ripple chain built from sub_x1_core.
module tb_sub_x1;

  logic clk = 1'b0;
  logic rst_n;
  logic A, B, borrow_in, in_valid;

  logic bo, d, boQ, dQ, ov;
  logic ptBo, ptD, ptBoQ, ptDQ, ptOv;

  logic [3:0] aVec, bVec, rippleDiff;
  logic       rippleBin;
  logic [4:0] borrowChain;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string      tag;
    logic [2:0] exp;
  } expT;

  expT combQ[$];
  expT regQ[$];

  logic holdDiff, holdBo;

  always #5 clk = ~clk;

  sub_x1 #(.REGISTERED(1'b1)) dutReg (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .borrow_in(borrow_in),
    .in_valid(in_valid), .borrow_out(bo), .diff(d),
    .borrow_out_q(boQ), .diff_q(dQ), .out_valid(ov)
  );

  sub_x1 #(.REGISTERED(1'b0)) dutPass (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .borrow_in(borrow_in),
    .in_valid(in_valid), .borrow_out(ptBo), .diff(ptD),
    .borrow_out_q(ptBoQ), .diff_q(ptDQ), .out_valid(ptOv)
  );

  assign borrowChain[0] = rippleBin;
  for (genvar g = 0; g < 4; g++) begin : gen_ripple
    sub_x1_core u_bit (
      .A(aVec[g]), .B(bVec[g]), .borrow_in(borrowChain[g]),
      .diff(rippleDiff[g]), .borrow_out(borrowChain[g+1])
    );
  end

  // Reference: {borrow_out, diff} is (a - b - bi) mod 4.
  function automatic logic [1:0] refSub(input logic a, input logic b, input logic bi);
    logic [1:0] r;
    r = {1'b0, a} - {1'b0, b} - {1'b0, bi};
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic a, input logic b, input logic bi, input logic v);
    expT e;
    logic [1:0] r;
    r = refSub(a, b, bi);
    A = a; B = b; borrow_in = bi; in_valid = v;
    e.tag = $sformatf("comb_%b%b%b", a, b, bi);
    e.exp = {v, r};
    combQ.push_back(e);
    if (rst_n) begin
      e.tag = $sformatf("reg_%b%b%b_v%b", a, b, bi, v);
      if (v) begin
        e.exp    = {1'b1, r};
        holdBo   = r[1];
        holdDiff = r[0];
      end else begin
        e.exp = {1'b0, holdBo, holdDiff};
      end
      regQ.push_back(e);
    end
  endtask

  task automatic checkComb();
    expT e;
    if (combQ.size() == 0) begin
      checkOutput("combUnderflow", 8'(combQ.size()), 8'd1);
      return;
    end
    e = combQ.pop_front();
    checkOutput(e.tag, {6'd0, bo, d}, {6'd0, e.exp[1:0]});
    checkOutput({e.tag, "_pass"}, {5'd0, ptOv, ptBoQ, ptDQ}, {5'd0, e.exp});
  endtask

  task automatic checkReg();
    expT e;
    @(posedge clk);
    #1;
    if (regQ.size() == 0) begin
      checkOutput("regUnderflow", 8'(regQ.size()), 8'd1);
      return;
    end
    e = regQ.pop_front();
    checkOutput(e.tag, {5'd0, ov, boQ, dQ}, {5'd0, e.exp});
  endtask

  initial begin
    logic [3:0] ra, rb;
    logic       rbi;
    logic [4:0] rippleExp;

    rst_n = 1'b0;
    A = 1'b0; B = 1'b0; borrow_in = 1'b0; in_valid = 1'b0;
    holdDiff = 1'b0; holdBo = 1'b0;
    aVec = 4'd0; bVec = 4'd0; rippleBin = 1'b0;

    #2;
    checkOutput("resetState", {5'd0, ov, boQ, dQ}, 8'd0);

    // Exhaustive sweep while in reset: comb paths must still be live.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i[2], i[1], i[0], i[0]);
      #1;
      checkComb();
      #9;
    end
    checkOutput("resetHold", {5'd0, ov, boQ, dQ}, 8'd0);

    // Release reset and exercise capture then hold.
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    #1; checkComb();
    checkReg();
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    #1; checkComb();
    checkReg();

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    holdBo = 1'b0; holdDiff = 1'b0;
    #1;
    checkOutput("asyncReset", {5'd0, ov, boQ, dQ}, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    #1; checkComb();

    // Reset release followed by a capture.
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    #1; checkComb();
    checkReg();

    // Random traffic with sparse valids.
    repeat (24) begin
      @(negedge clk);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1; checkComb();
      checkReg();
    end

    // Pass-through ignores reset.
    @(negedge clk);
    rst_n = 1'b0;
    holdBo = 1'b0; holdDiff = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    #1; checkComb();

    // 4-bit ripple chain: directed case then random operands.
    aVec = 4'b0011; bVec = 4'b0101; rippleBin = 1'b0;
    #1;
    checkOutput("ripple_3m5", {3'd0, borrowChain[4], rippleDiff}, 8'b0001_1110);
    repeat (10) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rbi = 1'($urandom_range(0, 1));
      aVec = ra; bVec = rb; rippleBin = rbi;
      rippleExp = {1'b0, ra} - {1'b0, rb} - {4'd0, rbi};
      #1;
      checkOutput($sformatf("ripple_%0d_%0d_%0d", ra, rb, rbi),
                  {3'd0, borrowChain[4], rippleDiff}, {3'd0, rippleExp});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
